control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 pm_addr  output  8  program-memory address, always equal to PC; memory is synchronous, so pm_data is valid one cycle later.
REQ-004 pm_data  input  8  instruction/operand byte; instruction format is instr[7:4]=opcode, instr[3]=reserved 0, instr[2:0]=register index.
REQ-005 alu_code  output  3  ALU operation code (ADD/SUB/AND/OR/XOR/NOT/LD per shared defines).
REQ-006 alu_ci  output  1  ALU carry-in.
REQ-007 alu_co  input  1  ALU carry-out.
REQ-008 alu_out  input  8  ALU result, used for zero flag.
REQ-009 reg_sel  output  3  register-file index, equal to IR[2:0].
REQ-010 reg_we  output  1  register-file write strobe (writes accumulator into R[reg_sel]).
REQ-011 acc_we  output  1  accumulator write strobe.
REQ-012 acc_src  output  1  accumulator source: 0=alu_out, 1=imm.
REQ-013 imm  output  8  operand byte of current two-byte instruction.
REQ-014 flag_c, flag_z  output  1 each  carry and zero flags.
REQ-015 halted  output  1  high while in HALT state.

Function
REQ-016 Opcodes: 0 NOP, 1 ADD, 2 ADC, 3 SUB, 4 SBC, 5 AND, 6 OR, 7 XOR, 8 NOT, 9 LD, A ST, B LDI, C JMP, D JZ, E JC, F HLT; B-E are two-byte (operand follows).
REQ-017 States: FETCH, DECODE, OPND_ADDR, OPND, EXEC, HALT.
REQ-018 FETCH -> DECODE unconditionally.
REQ-019 DECODE: IR <= pm_data, PC <= PC+1; next OPND_ADDR if two-byte, HLT -> HALT, else EXEC.
REQ-020 OPND_ADDR -> OPND (wait cycle for memory at new PC).
REQ-021 OPND: operand register <= pm_data, PC <= PC+1; next EXEC.
REQ-022 EXEC -> FETCH always; one-byte instructions take 3 cycles, two-byte 5 cycles.
REQ-023 HALT is terminal until reset; all strobes 0, PC frozen.
REQ-024 acc_we and reg_we are high only in EXEC, for exactly one cycle: acc_we for opcodes 1-9 and B; reg_we for A.
REQ-025 alu_code, alu_ci, reg_sel, acc_src are combinational from IR/flags and valid throughout EXEC.
REQ-026 ADC/SBC drive alu_ci=flag_c; all other opcodes drive alu_ci=0.
REQ-027 At end of EXEC for opcodes 1-9: flag_c <= alu_co, flag_z <= (alu_out==0); all other opcodes leave flags unchanged.
REQ-028 JMP: PC <= operand in EXEC; JZ/JC: PC <= operand if flag_z/flag_c is 1, else PC unchanged.
REQ-029 PC is 8-bit and wraps 0xFF -> 0x00, including operand fetch across the wrap.
REQ-030 Reserved bit instr[3]=1 is ignored (decoded as if 0).
REQ-031 NOP: no strobes, no flag change, 3 cycles.

Reset
REQ-032 rst_n low asynchronously forces state=FETCH, PC=0x00, IR=0x00 (NOP), operand=0x00, flag_c=0, flag_z=0, halted=0, acc_we=0, reg_we=0, imm=0x00.
REQ-033 Reset asserted mid-instruction aborts it with no strobe issued; the first fetch after release is from address 0x00.

Structure
REQ-034 Opcode values, ALU codes and state encoding live in the shared defines/package, also used by the ALU.
REQ-035 Combinational decode (opcode -> alu_code, strobe enables, two-byte flag) is one sub-module, instr_decode; the FSM, PC, IR and flags stay in control_unit.

Verification
REQ-036 Reset then program {B0 05, 10}: LDI 0x05 -> acc_we with acc_src=1, imm=0x05 in cycle 5; ADD R0 -> acc_we, alu_code=ADD, alu_ci=0 in cycle 8.
REQ-037 ADD with alu_co=1, alu_out=0x00 -> flag_c=1, flag_z=1 next cycle; following ADC drives alu_ci=1.
REQ-038 JZ 0x40 with flag_z=1 -> pm_addr=0x40 at next FETCH; with flag_z=0 -> pm_addr=PC after operand.
REQ-039 LDI placed at 0xFF: operand fetched from 0x00, next FETCH at 0x01.
REQ-040 HLT -> halted=1, pm_addr and strobes frozen for 20 cycles; rst_n pulse -> pm_addr=0x00, halted=0.
REQ-041 rst_n asserted during OPND of JMP 0x80 -> no jump, flags 0, restart at 0x00.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared opcode, ALU-code and FSM-state definitions for the control unit and the ALU.
package control_unit_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_ADD = 4'h1, OP_ADC = 4'h2, OP_SUB = 4'h3,
        OP_SBC = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
        OP_NOT = 4'h8, OP_LD  = 4'h9, OP_ST  = 4'hA, OP_LDI = 4'hB,
        OP_JMP = 4'hC, OP_JZ  = 4'hD, OP_JC  = 4'hE, OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3,
        ALU_XOR = 3'd4, ALU_NOT = 3'd5, ALU_LD  = 3'd6
    } alu_code_e;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_OPND_ADDR = 3'd2,
        ST_OPND      = 3'd3,
        ST_EXEC      = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        BR_NONE   = 2'd0,
        BR_ALWAYS = 2'd1,
        BR_ZERO   = 2'd2,
        BR_CARRY  = 2'd3
    } branch_e;

    typedef struct packed {
        alu_code_e alu_code;
        logic      acc_we;
        logic      reg_we;
        logic      flag_we;
        logic      use_carry;
        logic      acc_src;
        branch_e   branch;
    } decode_t;

    // Decided on the raw fetched byte, before it has been latched into IR.
    function automatic logic is_two_byte(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
    endfunction

    function automatic logic is_halt(input logic [3:0] op);
        return op == OP_HLT;
    endfunction

endpackage

// File: rtl/control_unit_instr_decode.sv
// Purely combinational opcode decode: ALU operation, strobe enables, flag update and branch kind.
module instr_decode
    import control_unit_pkg::*;
(
    input  logic [3:0] opcode,
    output decode_t    dec
);

    always_comb begin
        dec          = '0;
        dec.alu_code = ALU_ADD;
        dec.branch   = BR_NONE;
        case (opcode_e'(opcode))
            OP_ADD: begin dec.acc_we = 1'b1; dec.flag_we = 1'b1; end
            OP_ADC: begin dec.acc_we = 1'b1; dec.flag_we = 1'b1; dec.use_carry = 1'b1; end
            OP_SUB: begin dec.acc_we = 1'b1; dec.flag_we = 1'b1; dec.alu_code = ALU_SUB; end
            OP_SBC: begin
                dec.acc_we    = 1'b1;
                dec.flag_we   = 1'b1;
                dec.use_carry = 1'b1;
                dec.alu_code  = ALU_SUB;
            end
            OP_AND: begin dec.acc_we = 1'b1; dec.flag_we = 1'b1; dec.alu_code = ALU_AND; end
            OP_OR:  begin dec.acc_we = 1'b1; dec.flag_we = 1'b1; dec.alu_code = ALU_OR;  end
            OP_XOR: begin dec.acc_we = 1'b1; dec.flag_we = 1'b1; dec.alu_code = ALU_XOR; end
            OP_NOT: begin dec.acc_we = 1'b1; dec.flag_we = 1'b1; dec.alu_code = ALU_NOT; end
            OP_LD:  begin dec.acc_we = 1'b1; dec.flag_we = 1'b1; dec.alu_code = ALU_LD;  end
            OP_ST:  dec.reg_we = 1'b1;
            OP_LDI: begin dec.acc_we = 1'b1; dec.acc_src = 1'b1; end
            OP_JMP: dec.branch = BR_ALWAYS;
            OP_JZ:  dec.branch = BR_ZERO;
            OP_JC:  dec.branch = BR_CARRY;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: fetch/decode/operand/execute FSM with PC, IR, operand register and C/Z flags.
module control_unit
    import control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] pm_addr,
    input  logic [7:0] pm_data,
    output logic [2:0] alu_code,
    output logic       alu_ci,
    input  logic       alu_co,
    input  logic [7:0] alu_out,
    output logic [2:0] reg_sel,
    output logic       reg_we,
    output logic       acc_we,
    output logic       acc_src,
    output logic [7:0] imm,
    output logic       flag_c,
    output logic       flag_z,
    output logic       halted
);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [3:0] ir_op_q, ir_op_d;
    logic [2:0] ir_reg_q, ir_reg_d;
    logic [7:0] opnd_q, opnd_d;
    logic       flag_c_q, flag_c_d;
    logic       flag_z_q, flag_z_d;
    decode_t    dec;

    instr_decode u_decode (
        .opcode (ir_op_q),
        .dec    (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:     state_d = ST_DECODE;
            ST_DECODE: begin
                if (is_halt(pm_data[7:4]))          state_d = ST_HALT;
                else if (is_two_byte(pm_data[7:4])) state_d = ST_OPND_ADDR;
                else                                state_d = ST_EXEC;
            end
            ST_OPND_ADDR: state_d = ST_OPND;
            ST_OPND:      state_d = ST_EXEC;
            ST_EXEC:      state_d = ST_FETCH;
            ST_HALT:      state_d = ST_HALT;
            default:      state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        pm_addr  = pc_q;
        alu_code = dec.alu_code;
        alu_ci   = dec.use_carry & flag_c_q;
        reg_sel  = ir_reg_q;
        acc_src  = dec.acc_src;
        imm      = opnd_q;
        flag_c   = flag_c_q;
        flag_z   = flag_z_q;
        acc_we   = (state_q == ST_EXEC) & dec.acc_we;
        reg_we   = (state_q == ST_EXEC) & dec.reg_we;
        halted   = (state_q == ST_HALT);
    end

    // Reserved instruction bit 3 is dropped when latching IR, so it can never affect decode.
    always_comb begin
        pc_d     = pc_q;
        ir_op_d  = ir_op_q;
        ir_reg_d = ir_reg_q;
        opnd_d   = opnd_q;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        case (state_q)
            ST_DECODE: begin
                ir_op_d  = pm_data[7:4];
                ir_reg_d = pm_data[2:0];
                pc_d     = pc_q + 8'd1;
            end
            ST_OPND: begin
                opnd_d = pm_data;
                pc_d   = pc_q + 8'd1;
            end
            ST_EXEC: begin
                if (dec.flag_we) begin
                    flag_c_d = alu_co;
                    flag_z_d = (alu_out == 8'h00);
                end
                case (dec.branch)
                    BR_ALWAYS: pc_d = opnd_q;
                    BR_ZERO:   if (flag_z_q) pc_d = opnd_q;
                    BR_CARRY:  if (flag_c_q) pc_d = opnd_q;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= 8'h00;
            ir_op_q  <= 4'h0;
            ir_reg_q <= 3'd0;
            opnd_q   <= 8'h00;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ir_op_q  <= ir_op_d;
            ir_reg_q <= ir_reg_d;
            opnd_q   <= opnd_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench: instruction-level reference model plus directed scenarios and random programs.
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] pm_addr;
    logic [7:0] pm_data;
    logic [2:0] alu_code;
    logic       alu_ci;
    logic       alu_co;
    logic [7:0] alu_out;
    logic [2:0] reg_sel;
    logic       reg_we;
    logic       acc_we;
    logic       acc_src;
    logic [7:0] imm;
    logic       flag_c;
    logic       flag_z;
    logic       halted;

    control_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pm_addr  (pm_addr),
        .pm_data  (pm_data),
        .alu_code (alu_code),
        .alu_ci   (alu_ci),
        .alu_co   (alu_co),
        .alu_out  (alu_out),
        .reg_sel  (reg_sel),
        .reg_we   (reg_we),
        .acc_we   (acc_we),
        .acc_src  (acc_src),
        .imm      (imm),
        .flag_c   (flag_c),
        .flag_z   (flag_z),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous program memory: data for an address appears one cycle later.
    logic [7:0] mem [256];
    always @(posedge clk) pm_data <= mem[pm_addr];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_cmp = n_cmp + 1;
        if (actual !== expected) begin
            n_err = n_err + 1;
            $display("[TB] FAIL %s at cycle %0d: got 0x%02h, expected 0x%02h", name, cyc, actual, expected);
        end
    endtask

    // Reference model: one entry per expected cycle, generated an instruction at a time.
    typedef struct packed {
        logic [7:0] addr;
        logic       is_exec;
        logic       halt;
        logic [3:0] op;
        logic [2:0] rsel;
        logic [7:0] opnd;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] m_pc;
    logic       m_c;
    logic       m_z;
    logic       m_halted;

    function automatic logic [7:0] exp_alu_code(input logic [3:0] op);
        case (op)
            4'h1, 4'h2: return 8'd0;
            4'h3, 4'h4: return 8'd1;
            4'h5:       return 8'd2;
            4'h6:       return 8'd3;
            4'h7:       return 8'd4;
            4'h8:       return 8'd5;
            4'h9:       return 8'd6;
            default:    return 8'd0;
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_pc     = 8'h00;
        m_c      = 1'b0;
        m_z      = 1'b0;
        m_halted = 1'b0;
    endtask

    task automatic push(input logic [7:0] a, input logic ex, input logic h,
                        input logic [3:0] op, input logic [2:0] rs, input logic [7:0] od);
        exp_t e;
        e.addr = a; e.is_exec = ex; e.halt = h; e.op = op; e.rsel = rs; e.opnd = od;
        exp_q.push_back(e);
    endtask

    task automatic gen_instr();
        logic [7:0] pc, p1, p2, ins, od, nxt;
        logic [3:0] op;
        if (m_halted) begin
            push(m_pc, 1'b0, 1'b1, 4'h0, 3'd0, 8'h00);
            return;
        end
        pc  = m_pc;
        p1  = pc + 8'd1;
        p2  = pc + 8'd2;
        ins = mem[pc];
        op  = ins[7:4];
        od  = mem[p1];
        push(pc, 1'b0, 1'b0, op, ins[2:0], od);
        push(pc, 1'b0, 1'b0, op, ins[2:0], od);
        if (op == 4'hF) begin
            m_halted = 1'b1;
            m_pc     = p1;
        end else if (op >= 4'hB && op <= 4'hE) begin
            push(p1, 1'b0, 1'b0, op, ins[2:0], od);
            push(p1, 1'b0, 1'b0, op, ins[2:0], od);
            push(p2, 1'b1, 1'b0, op, ins[2:0], od);
            nxt = p2;
            if (op == 4'hC || (op == 4'hD && m_z) || (op == 4'hE && m_c)) nxt = od;
            m_pc = nxt;
        end else begin
            push(p1, 1'b1, 1'b0, op, ins[2:0], od);
            m_pc = p1;
        end
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        logic exp_acc;
        if (!rst_n) begin
            model_reset();
            checkOutput("reset pm_addr", pm_addr, 8'h00);
            checkOutput("reset acc_we", 8'(acc_we), 8'h00);
            checkOutput("reset reg_we", 8'(reg_we), 8'h00);
            checkOutput("reset halted", 8'(halted), 8'h00);
            checkOutput("reset flag_c", 8'(flag_c), 8'h00);
            checkOutput("reset flag_z", 8'(flag_z), 8'h00);
            checkOutput("reset imm", imm, 8'h00);
        end else begin
            if (exp_q.size() == 0) gen_instr();
            e       = exp_q.pop_front();
            exp_acc = e.is_exec && ((e.op >= 4'h1 && e.op <= 4'h9) || e.op == 4'hB);
            checkOutput("pm_addr", pm_addr, e.addr);
            checkOutput("halted", 8'(halted), 8'(e.halt));
            checkOutput("acc_we", 8'(acc_we), 8'(exp_acc));
            checkOutput("reg_we", 8'(reg_we), 8'(e.is_exec && e.op == 4'hA));
            checkOutput("flag_c", 8'(flag_c), 8'(m_c));
            checkOutput("flag_z", 8'(flag_z), 8'(m_z));
            if (e.is_exec) begin
                checkOutput("alu_ci", 8'(alu_ci), 8'((e.op == 4'h2 || e.op == 4'h4) && m_c));
                if (exp_acc) checkOutput("acc_src", 8'(acc_src), 8'(e.op == 4'hB));
                if (exp_acc && e.op != 4'hB) begin
                    checkOutput("alu_code", 8'(alu_code), exp_alu_code(e.op));
                    checkOutput("reg_sel", 8'(reg_sel), 8'(e.rsel));
                end
                if (e.op == 4'hA) checkOutput("st reg_sel", 8'(reg_sel), 8'(e.rsel));
                if (e.op == 4'hB) checkOutput("imm", imm, e.opnd);
                if (e.op >= 4'h1 && e.op <= 4'h9) begin
                    m_c = alu_co;
                    m_z = (alu_out == 8'h00);
                end
            end
        end
    end

    function automatic logic [7:0] rand_byte();
        if ($urandom_range(0, 3) == 0) return 8'h00;
        return 8'($urandom);
    endfunction

    // Advances into the next cycle and drives the ALU response seen during it.
    task automatic applyStimulus(input logic co, input logic [7:0] out);
        @(posedge clk);
        #1;
        alu_co  = co;
        alu_out = out;
        #1;
    endtask

    task automatic step_random(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'($urandom), rand_byte());
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] b;
        rst_n   = 1'b0;
        alu_co  = 1'b0;
        alu_out = 8'h00;
        clear_mem();

        // LDI 0x05 then ADD R0
        mem[0] = 8'hB0; mem[1] = 8'h05; mem[2] = 8'h10;
        release_reset();
        checkOutput("pin first fetch addr", pm_addr, 8'h00);
        repeat (4) applyStimulus(1'b0, 8'h11);
        checkOutput("pin ldi acc_we", 8'(acc_we), 8'h01);
        checkOutput("pin ldi acc_src", 8'(acc_src), 8'h01);
        checkOutput("pin ldi imm", imm, 8'h05);
        repeat (3) applyStimulus(1'b0, 8'h07);
        checkOutput("pin add acc_we", 8'(acc_we), 8'h01);
        checkOutput("pin add alu_code", 8'(alu_code), 8'h00);
        checkOutput("pin add alu_ci", 8'(alu_ci), 8'h00);

        // ADD sets C and Z, ADC then uses the carry
        assert_reset();
        clear_mem();
        mem[0] = 8'h11; mem[1] = 8'h21;
        release_reset();
        applyStimulus(1'b0, 8'h33);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b0, 8'h33);
        checkOutput("pin flag_c after add", 8'(flag_c), 8'h01);
        checkOutput("pin flag_z after add", 8'(flag_z), 8'h01);
        repeat (2) applyStimulus(1'b0, 8'h33);
        checkOutput("pin adc alu_ci", 8'(alu_ci), 8'h01);
        checkOutput("pin adc reg_sel", 8'(reg_sel), 8'h01);

        // JZ 0x40 taken, then not taken
        assert_reset();
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'hD0; mem[2] = 8'h40;
        release_reset();
        applyStimulus(1'b0, 8'h12);
        applyStimulus(1'b0, 8'h00);
        repeat (6) applyStimulus(1'b0, 8'h12);
        checkOutput("pin jz taken addr", pm_addr, 8'h40);
        assert_reset();
        release_reset();
        applyStimulus(1'b0, 8'h12);
        applyStimulus(1'b0, 8'h01);
        repeat (6) applyStimulus(1'b0, 8'h12);
        checkOutput("pin jz not taken addr", pm_addr, 8'h03);

        // JMP 0xFF, LDI straddling the wrap, then HLT (reserved bit set) at 0x01
        assert_reset();
        clear_mem();
        mem[0] = 8'hC0; mem[1] = 8'hFF; mem[255] = 8'hB0;
        release_reset();
        step_random(7);
        checkOutput("pin wrap operand addr", pm_addr, 8'h00);
        step_random(2);
        checkOutput("pin wrap ldi acc_we", 8'(acc_we), 8'h01);
        checkOutput("pin wrap ldi imm", imm, 8'hC0);
        step_random(1);
        checkOutput("pin wrap next fetch", pm_addr, 8'h01);
        step_random(2);
        for (int i = 0; i < 20; i++) begin
            checkOutput("pin halt halted", 8'(halted), 8'h01);
            checkOutput("pin halt pm_addr", pm_addr, 8'h02);
            checkOutput("pin halt strobes", 8'({acc_we, reg_we}), 8'h00);
            step_random(1);
        end
        assert_reset();
        release_reset();
        checkOutput("pin unhalt pm_addr", pm_addr, 8'h00);
        checkOutput("pin unhalt halted", 8'(halted), 8'h00);

        // Reset during the operand cycle of JMP 0x80
        assert_reset();
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'hC0; mem[2] = 8'h80;
        release_reset();
        applyStimulus(1'b0, 8'h44);
        applyStimulus(1'b1, 8'h00);
        repeat (3) applyStimulus(1'b0, 8'h44);
        checkOutput("pin pre-abort flag_c", 8'(flag_c), 8'h01);
        assert_reset();
        checkOutput("pin abort flag_c", 8'(flag_c), 8'h00);
        checkOutput("pin abort flag_z", 8'(flag_z), 8'h00);
        checkOutput("pin abort acc_we", 8'(acc_we), 8'h00);
        release_reset();
        checkOutput("pin restart addr", pm_addr, 8'h00);
        step_random(1);
        checkOutput("pin no jump addr", pm_addr, 8'h00);

        // Random programs with occasional mid-run resets
        for (int r = 0; r < 10; r++) begin
            assert_reset();
            for (int i = 0; i < 256; i++) begin
                b = 8'($urandom);
                if (b[7:4] == 4'hF && $urandom_range(0, 7) != 0) b[7:4] = 4'h0;
                mem[i] = b;
            end
            release_reset();
            for (int k = 0; k < 300; k++) begin
                step_random(1);
                if ($urandom_range(0, 149) == 0) begin
                    assert_reset();
                    release_reset();
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
